// File: rtl/rpi_sample_burst_tx.sv
// rpi_sample_burst_tx: FIFO-buffered sample words sent to the RPi as fixed-length MSB-first serial bursts.
// Latency: a push shows in fill_level next cycle; irq_out rises 1 cycle after fill_level >= THRESH.
// Backpressure: sample_ready = !full; a word offered while full is dropped and sets sticky overflow.
//
// Ports:
//   clk_in, reset          system clock (rising edge), synchronous active-high reset
//   sample_in/_valid/_ready capture-path push interface (push = valid & ready)
//   irq_out                high for the whole burst (RPi clock stage interrupt_enable)
//   sclk_out, sdata_out    serial bit clock and MSB-first data; RPi samples on sclk rise
//   fill_level             words currently held in the FIFO
//   overflow               sticky, set when a word was offered while full
// Optional feature macro: RPI_BURST_PARITY_EN appends one even-parity bit after each word.
module rpi_sample_burst_tx #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int THRESH     = 8,
  parameter int DIV_LOG2   = 5,
  parameter int GAP_CYC    = 64
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  irq_out,
  output logic                  sclk_out,
  output logic                  sdata_out,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef RPI_BURST_PARITY_EN
  localparam int W = DATA_W + 1;
`else
  localparam int W = DATA_W;
`endif
  localparam int BC_W = (W > 1) ? $clog2(W) : 1;
  localparam int WL_W = $clog2(THRESH + 1);
  localparam int GC_W = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  full, push, pop;
  logic [DATA_W-1:0]     head_dat;
  logic [W-1:0]          word_load;
  logic [W-1:0]          shreg;
  logic [DIV_LOG2:0]     divider;
  logic [BC_W-1:0]       bit_cnt;
  logic [WL_W-1:0]       words_left;
  logic [GC_W-1:0]       gap_cnt;
  logic                  irq_q;
  logic                  bit_end, word_end;

  // ---------------- FIFO ----------------
  assign full         = (fill_level == (DEPTH_LOG2+1)'(DEPTH));
  assign sample_ready = ~full;
  assign push         = sample_valid & ~full;
  assign head_dat     = mem[rd_ptr];

`ifdef RPI_BURST_PARITY_EN
  // Parity rides in the LSB so it is shifted out after the data bits.
  assign word_load = {head_dat, ^head_dat};
`else
  assign word_load = head_dat;
`endif

  // Storage is not reset; only pointers and the fill count define validity.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
      if (sample_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------- burst FSM ----------------
  // divider is all-ones on the last cycle of a bit period.
  assign bit_end  = (divider == '1);
  assign word_end = bit_end && (bit_cnt == BC_W'(W - 1));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fill_level >= (DEPTH_LOG2+1)'(THRESH)) begin
          pop     = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (word_end) begin
          if (words_left != '0) begin
            pop = 1'b1;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GC_W'(GAP_CYC - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath. divider and shreg are zero outside SHIFT so sclk_out and
  // sdata_out can be taken straight from register bits without gating.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      shreg      <= '0;
      divider    <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      gap_cnt    <= '0;
      irq_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shreg      <= word_load;
            words_left <= WL_W'(THRESH - 1);
            divider    <= '0;
            bit_cnt    <= '0;
            irq_q      <= 1'b1;
          end
        end
        SHIFT: begin
          // Wraps to zero at the end of every bit, including the last one.
          divider <= divider + 1'b1;
          if (bit_end) begin
            if (!word_end) begin
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + 1'b1;
            end else if (pop) begin
              shreg      <= word_load;
              bit_cnt    <= '0;
              words_left <= words_left - 1'b1;
            end else begin
              shreg   <= '0;
              bit_cnt <= '0;
              gap_cnt <= '0;
              irq_q   <= 1'b0;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign irq_out   = irq_q;
  assign sclk_out  = divider[DIV_LOG2];
  assign sdata_out = shreg[W-1];

endmodule

// File: tb/tb_rpi_sample_burst_tx.sv
`timescale 1ns/1ps
// tb_rpi_sample_burst_tx: directed bench for the RPi burst transmitter.
// Latency: checks irq rise 1 cycle after fill reaches THRESH and the 65-cycle inter-burst gap.
// Backpressure: fills the FIFO during a burst to exercise sample_ready and sticky overflow.
module tb_rpi_sample_burst_tx;

  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 4;
  localparam int THRESH     = 4;
  localparam int DIV_LOG2   = 5;
  localparam int GAP_CYC    = 64;
  localparam int BP         = 64;
`ifdef RPI_BURST_PARITY_EN
  localparam int W = 17;
`else
  localparam int W = 16;
`endif
  localparam int BURST_LEN = THRESH * W * BP;

  logic                clk_in = 1'b0;
  logic                reset;
  logic [DATA_W-1:0]   sample_in;
  logic                sample_valid;
  logic                sample_ready;
  logic                irq_out;
  logic                sclk_out;
  logic                sdata_out;
  logic [DEPTH_LOG2:0] fill_level;
  logic                overflow;

  int n_vec = 0;
  int n_err = 0;

  rpi_sample_burst_tx #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .THRESH    (THRESH),
    .DIV_LOG2  (DIV_LOG2),
    .GAP_CYC   (GAP_CYC)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .irq_out     (irq_out),
    .sclk_out    (sclk_out),
    .sdata_out   (sdata_out),
    .fill_level  (fill_level),
    .overflow    (overflow)
  );

  always #5 clk_in = ~clk_in;

  // Serial receiver: samples on the falling system edge, captures on sclk rise.
  logic         sclk_prev = 1'b0;
  logic [W-1:0] mon_word  = '0;
  int           mon_bits  = 0;
  logic [W-1:0] rx_q [$];

  always @(negedge clk_in) begin
    sclk_prev <= sclk_out;
    if (reset) begin
      mon_bits <= 0;
      mon_word <= '0;
    end else if (sclk_out && !sclk_prev) begin
      if (mon_bits == W - 1) begin
        rx_q.push_back({mon_word[W-2:0], sdata_out});
        mon_bits <= 0;
      end else begin
        mon_word <= {mon_word[W-2:0], sdata_out};
        mon_bits <= mon_bits + 1;
      end
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d);
    sample_in    = d;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  // Serial word as it should appear on the wire.
  function automatic logic [31:0] exp_word(input logic [15:0] d);
`ifdef RPI_BURST_PARITY_EN
    return {15'd0, d, ^d};
`else
    return {16'd0, d};
`endif
  endfunction

  task automatic check_rx(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    if (rx_q.size() > 0) got = 32'(rx_q.pop_front());
    else                 got = 'x;
    check_vec(tag, got, exp);
  endtask

  // Polls until irq_out equals lvl, bounded; an expired bound fails the compare.
  task automatic wait_irq(input string tag, input logic lvl, input int budget);
    int cyc;
    cyc = 0;
    while (irq_out !== lvl && cyc < budget) begin
      tick(1);
      cyc++;
    end
    check_vec(tag, 32'(irq_out), 32'(lvl));
  endtask

  // Counts consecutive sampled cycles with irq_out == lvl, starting now.
  task automatic count_level(input logic lvl, output int cnt);
    cnt = 0;
    while (irq_out === lvl && cnt < 10000) begin
      cnt++;
      tick(1);
    end
  endtask

  logic [15:0] vec_a [4] = '{16'hA5C3, 16'h1234, 16'h0F0F, 16'hFFFF};
  logic [15:0] vec_b [8] = '{16'h0001, 16'h8000, 16'hAAAA, 16'h5555,
                             16'hC0DE, 16'h7E57, 16'h0000, 16'hFFFE};
  logic [15:0] vec_c [4] = '{16'h1357, 16'h2468, 16'h9BDF, 16'hACE0};

  initial begin
    int cnt;
    int guard;
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    tick(3);
    reset = 1'b0;

    // ---- reset state ----
    check_vec("rst_fill", 32'(fill_level), 0);
    check_vec("rst_irq", 32'(irq_out), 0);
    check_vec("rst_sclk", 32'(sclk_out), 0);
    check_vec("rst_sdata", 32'(sdata_out), 0);
    check_vec("rst_ovf", 32'(overflow), 0);
    check_vec("rst_ready", 32'(sample_ready), 1);

    // ---- reset clears a partially filled FIFO ----
    for (int i = 0; i < 3; i++) push_word(vec_a[i]);
    check_vec("pre_rst_fill", 32'(fill_level), 3);
    do_reset();
    check_vec("post_rst_fill", 32'(fill_level), 0);
    check_vec("post_rst_irq", 32'(irq_out), 0);
    check_vec("post_rst_ovf", 32'(overflow), 0);
    push_word(16'h4444);
    tick(10);
    check_vec("no_burst_irq", 32'(irq_out), 0);
    check_vec("no_burst_fill", 32'(fill_level), 1);
    do_reset();
    rx_q.delete();

    // ---- threshold burst ----
    for (int i = 0; i < 3; i++) push_word(vec_a[i]);
    check_vec("thr_fill3", 32'(fill_level), 3);
    check_vec("thr_irq_below", 32'(irq_out), 0);
    push_word(vec_a[3]);
    check_vec("thr_fill4", 32'(fill_level), 4);
    check_vec("thr_irq_same_cyc", 32'(irq_out), 0);
    tick(1);
    check_vec("thr_irq_rise", 32'(irq_out), 1);
    check_vec("thr_fill_pop", 32'(fill_level), 3);
    count_level(1'b1, cnt);
    check_vec("thr_burst_len", 32'(cnt), 32'(BURST_LEN));
    check_vec("thr_fill_end", 32'(fill_level), 0);
    check_vec("thr_sclk_end", 32'(sclk_out), 0);
    check_vec("thr_sdata_end", 32'(sdata_out), 0);
    check_vec("thr_rx_count", 32'(rx_q.size()), 4);
    for (int i = 0; i < 4; i++) check_rx($sformatf("thr_w%0d", i), exp_word(vec_a[i]));

    // ---- pushes during a burst, back-to-back second burst ----
    tick(100);
    do_reset();
    rx_q.delete();
    for (int i = 0; i < 4; i++) push_word(vec_b[i]);
    wait_irq("cc_start", 1'b1, 20);
    for (int i = 4; i < 8; i++) begin
      tick(99);
      push_word(vec_b[i]);
    end
    wait_irq("cc_end1", 1'b0, 6000);
    check_vec("cc_fill_gap", 32'(fill_level), 4);
    count_level(1'b0, cnt);
    check_vec("cc_gap_len", 32'(cnt), 32'(GAP_CYC + 1));
    count_level(1'b1, cnt);
    check_vec("cc_burst2_len", 32'(cnt), 32'(BURST_LEN));
    check_vec("cc_rx_count", 32'(rx_q.size()), 8);
    for (int i = 0; i < 8; i++) check_rx($sformatf("cc_w%0d", i), exp_word(vec_b[i]));

    // ---- overflow: fill to capacity while a burst drains slowly ----
    do_reset();
    rx_q.delete();
    for (int i = 0; i < 4; i++) push_word(16'h1000 + 16'(i));
    guard = 0;
    while (sample_ready && guard < 40) begin
      sample_in    = 16'h2000 + 16'(guard);
      sample_valid = 1'b1;
      tick(1);
      guard++;
    end
    sample_valid = 1'b0;
    check_vec("ovf_accepted", 32'(guard), 13);
    check_vec("ovf_full_fill", 32'(fill_level), 16);
    check_vec("ovf_ready_low", 32'(sample_ready), 0);
    check_vec("ovf_not_yet", 32'(overflow), 0);
    push_word(16'hBAD0);
    check_vec("ovf_set", 32'(overflow), 1);
    check_vec("ovf_drop_fill", 32'(fill_level), 16);
    tick(1100);
    check_vec("ovf_sticky", 32'(overflow), 1);
    check_vec("ovf_drain_fill", 32'(fill_level), 15);
    check_vec("ovf_ready_back", 32'(sample_ready), 1);

    // ---- reset in the middle of a burst ----
    do_reset();
    check_vec("mid_ovf_clr", 32'(overflow), 0);
    rx_q.delete();
    for (int i = 0; i < 4; i++) push_word(16'hDEAD);
    wait_irq("mid_start", 1'b1, 20);
    tick(499);
    check_vec("mid_irq_500", 32'(irq_out), 1);
    do_reset();
    check_vec("mid_irq", 32'(irq_out), 0);
    check_vec("mid_sclk", 32'(sclk_out), 0);
    check_vec("mid_sdata", 32'(sdata_out), 0);
    check_vec("mid_fill", 32'(fill_level), 0);
    tick(100);
    check_vec("mid_quiet", 32'(irq_out), 0);
    rx_q.delete();
    for (int i = 0; i < 4; i++) push_word(vec_c[i]);
    wait_irq("mid_restart", 1'b1, 20);
    count_level(1'b1, cnt);
    check_vec("mid_burst_len", 32'(cnt), 32'(BURST_LEN));
    for (int i = 0; i < 4; i++) check_rx($sformatf("mid_w%0d", i), exp_word(vec_c[i]));

`ifdef RPI_BURST_PARITY_EN
    // ---- parity bit after each word ----
    tick(100);
    rx_q.delete();
    push_word(16'h0001);
    push_word(16'h0003);
    push_word(16'h0001);
    push_word(16'h0003);
    wait_irq("par_start", 1'b1, 20);
    count_level(1'b1, cnt);
    check_vec("par_burst_len", 32'(cnt), 4352);
    check_rx("par_w0", 32'h0000_0003);
    check_rx("par_w1", 32'h0000_0006);
    check_rx("par_w2", 32'h0000_0003);
    check_rx("par_w3", 32'h0000_0006);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
